switch_allocator: RTL
=====================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter: RR_INIT, default 0, initial round-robin pointer value (0..4) loaded into every output port on reset.
REQ-002 SHALL use port index encoding Core=0, E=1, N=2, W=3, S=4 for all per-port vectors; bit/field k belongs to port k.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req_valid  input  5  input port k holds a flit.
REQ-006 SHALL have port: req_head  input  5  flit at input k is a head flit (bit 33 of the flit).
REQ-007 SHALL have port: req_tail  input  5  flit at input k is a tail flit (bit 32 of the flit).
REQ-008 SHALL have port: req_dir  input  15  3-bit requested output port per input, field k = bits [3k+2:3k]; meaningful only with head.
REQ-009 SHALL have port: out_ready  input  5  downstream of output port o accepts a flit this cycle.
REQ-010 SHALL have port: grant_valid  output  5  output port o is locked to an owner (registered).
REQ-011 SHALL have port: grant_src  output  15  3-bit owner input index per output port (registered; 0 when not locked).
REQ-012 SHALL have port: in_pop  output  5  flit at input k is transferred this cycle (combinational).
REQ-013 SHALL have port: err  output  1  sticky protocol error flag (registered).

Function
REQ-014 SHALL implement per output port an FSM with states IDLE and LOCKED; grant_valid[o]=1 exactly in LOCKED.
REQ-015 SHALL define input k as a candidate for port o when req_valid[k] & req_head[k] & req_dir[k]==o & input k is not bound to any port.
REQ-016 SHALL, in IDLE with at least one candidate, select the first candidate searching indices ptr[o], ptr[o]+1, ... modulo 5, and enter LOCKED next cycle with grant_src[o]=winner.
REQ-017 SHALL mark the winner bound from the cycle grant_valid rises until the cycle after its tail transfer.
REQ-018 SHALL define transfer on port o as LOCKED & out_ready[o] & req_valid[grant_src[o]]; in_pop[grant_src[o]]=1 in that same cycle, else 0.
REQ-019 SHALL, on a transfer with req_tail[owner]=1, return port o to IDLE next cycle, clear grant_src[o] to 0, and set ptr[o]=(owner+1) mod 5.
REQ-020 SHALL treat head+tail on one flit as a single-flit packet: granted per REQ-016, released per REQ-019.
REQ-021 SHALL give minimum latency: head at cycle 0 in IDLE -> grant_valid at cycle 1 -> first in_pop at cycle 1 if out_ready; one IDLE cycle follows every tail transfer.
REQ-022 SHALL hold LOCKED indefinitely while out_ready or owner req_valid is low; no timeout, no pre-emption.
REQ-023 SHALL never pop an unbound input or a candidate in its arbitration cycle; at most one in_pop bit per owner per cycle.
REQ-024 SHALL arbitrate all five ports independently in the same cycle; an input requests only one port, so no cross-port conflict exists.
REQ-025 SHALL set err=1 (sticky until reset) when an unbound input shows req_valid&req_head with req_dir>4 (request ignored), or req_valid&~req_head (orphan body flit, not popped).
REQ-026 SHALL leave ptr[o] unchanged when a port stays IDLE with no candidate.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, force all ports to IDLE, grant_valid=0, grant_src=0, err=0, all bindings cleared, ptr[o]=RR_INIT.
REQ-028 SHALL hold in_pop=0 whenever rst=1, including reset asserted mid-packet; the interrupted packet is abandoned, not resumed.

Verification
REQ-029 SHALL pass: input 0 head to dir 1, out_ready[1]=1, 3-flit packet -> grant_valid[1]=1, grant_src[1]=0 at cycle 1; in_pop[0] cycles 1-3; grant_valid[1]=0 at cycle 4.
REQ-030 SHALL pass: inputs 1,2,3 heads to port 4 simultaneously, single-flit packets, RR_INIT=0 -> grant order 1,2,3, each owner popped once, one IDLE cycle between grants.
REQ-031 SHALL pass: locked to input 2 with out_ready low 5 cycles -> grant held, in_pop=0 throughout; input 4 head to same port not granted until after tail.
REQ-032 SHALL pass: input 3 head with req_dir=6 -> no grant, in_pop=0, err=1 next cycle and stays 1 until rst.
REQ-033 SHALL pass: rst asserted while port 0 mid-packet -> next cycle grant_valid=0, grant_src=0, err=0, ptr=RR_INIT; a new head is granted normally afterward.

Source files
------------

// File: rtl/switch_allocator.sv
// Five-port wormhole switch allocator: one IDLE/LOCKED owner FSM per output port,
// round-robin head arbitration, combinational pop of the owner's flit on transfer.
module switch_allocator #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req_valid,
    input  logic [4:0]  req_head,
    input  logic [4:0]  req_tail,
    input  logic [14:0] req_dir,
    input  logic [4:0]  out_ready,
    output logic [4:0]  grant_valid,
    output logic [14:0] grant_src,
    output logic [4:0]  in_pop,
    output logic        err
);
    localparam int NP = 5;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} port_state_t;

    logic [4:0] bound;
    logic [4:0] bad_req;
    logic [4:0] pop_mask [NP];
    logic       err_reg;

    // An input is bound while some output port is locked to it.
    always_comb begin
        bound = '0;
        for (int k = 0; k < NP; k++) begin
            for (int o = 0; o < NP; o++) begin
                if (grant_valid[o] && grant_src[3*o +: 3] == 3'(k)) begin
                    bound[k] = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            port_state_t state_reg, state_next;
            logic [2:0]  src_reg, src_next;
            logic [2:0]  ptr_reg, ptr_next;
            logic [4:0]  cand;
            logic [2:0]  win;
            logic        found;
            logic        xfer;

            always_comb begin
                for (int k = 0; k < NP; k++) begin
                    cand[k] = req_valid[k] & req_head[k] & ~bound[k] &
                              (req_dir[3*k +: 3] == 3'(gi));
                end
            end

            // First candidate at or after the pointer, wrapping modulo five.
            always_comb begin
                win   = '0;
                found = 1'b0;
                for (int i = 0; i < NP; i++) begin
                    if (!found && cand[(int'(ptr_reg) + i) % NP]) begin
                        found = 1'b1;
                        win   = 3'((int'(ptr_reg) + i) % NP);
                    end
                end
            end

            assign xfer = (state_reg == LOCKED) & out_ready[gi] & req_valid[src_reg];

            always_comb begin
                state_next = state_reg;
                src_next   = src_reg;
                ptr_next   = ptr_reg;
                case (state_reg)
                    IDLE: begin
                        if (found) begin
                            state_next = LOCKED;
                            src_next   = win;
                        end
                    end
                    LOCKED: begin
                        if (xfer && req_tail[src_reg]) begin
                            state_next = IDLE;
                            src_next   = '0;
                            ptr_next   = (src_reg == 3'd4) ? 3'd0 : src_reg + 3'd1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= IDLE;
                    src_reg   <= '0;
                    ptr_reg   <= 3'(RR_INIT);
                end else begin
                    state_reg <= state_next;
                    src_reg   <= src_next;
                    ptr_reg   <= ptr_next;
                end
            end

            assign pop_mask[gi]           = (xfer && !rst) ? (5'b00001 << src_reg) : 5'b00000;
            assign grant_valid[gi]        = (state_reg == LOCKED);
            assign grant_src[3*gi +: 3]   = src_reg;
        end
    endgenerate

    // Owners are unique across ports, so OR-ing the per-port masks cannot collide.
    always_comb begin
        in_pop = '0;
        for (int o = 0; o < NP; o++) begin
            in_pop = in_pop | pop_mask[o];
        end
    end

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            bad_req[k] = req_valid[k] & ~bound[k] &
                         (~req_head[k] | (req_dir[3*k +: 3] > 3'd4));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | (|bad_req);
        end
    end

    assign err = err_reg;

endmodule
